mips_mem_responder: RTL and testbench
=====================================

Name: mips_mem_responder

Overview:
- Memory-side responder for the 8-bit multicycle MIPS core.
- Answers the core's memread/memwrite/adr/writedata requests with a byte-wide RAM and a small memory-mapped I/O window.
- Contains a byte-serial boot loader that fills RAM while holding the core in reset, then releases it.
- Sits beside the core at top level and drives the core's reset and memdata inputs.

Parameters:
WIDTH, 8, address/data width; RAM depth is 2^WIDTH minus the I/O window.
IO_BASE, 8'hF0, first address of the 16-byte I/O window (IO_BASE..IO_BASE+15).
TIMER_DIV, 4, clk cycles per timer tick (>=1).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
memread  in  1  core read request
memwrite  in  1  core write request
adr  in  WIDTH  core byte address
writedata  in  WIDTH  core write data
memdata  out  WIDTH  read data to core
load_valid  in  1  loader byte valid
load_data  in  8  loader byte
load_done  in  1  loader end-of-image pulse
load_ready  out  1  responder accepts a loader byte this cycle
cpu_reset  out  1  synchronous reset to core
leds  out  8  LED register
switches  in  8  asynchronous switch inputs

Behaviour:
- Reset (async): state=LOAD, load_ptr=0, cpu_reset=1, leds=0, timer=0, prescaler=0, ovf=0, switch sync flops=0. RAM contents are not reset.
- FSM states:
  - LOAD: load_ready=1, cpu_reset=1. On load_valid, RAM[load_ptr]<=load_data and load_ptr++.
    - Go to RELEASE when load_done=1, or when a byte is written at load_ptr=IO_BASE-1.
    - If load_valid and load_done occur in the same cycle, write the byte first, then transition.
  - RELEASE: exactly 1 cycle, cpu_reset=1, load_ready=0.
  - RUN: cpu_reset=0, load_ready=0. Loader inputs are ignored. Stays in RUN until reset.
- The core is held in reset for the whole of LOAD and RELEASE. Core requests in those states are ignored, and memdata=0.
- Reads (RUN only): memdata is combinational from adr when memread=1, because the core latches it on the same edge. memdata=0 when memread=0.
  - adr<IO_BASE: RAM[adr].
  - IO_BASE+0: leds.
  - IO_BASE+1: synchronized switches (2-flop synchronizer, 2-cycle latency).
  - IO_BASE+2: timer.
  - IO_BASE+3: {7'b0, ovf}.
  - Other I/O addresses: 0.
- Writes (RUN only): on posedge with memwrite=1.
  - adr<IO_BASE: RAM[adr]<=writedata.
  - IO_BASE+0: leds<=writedata.
  - All other I/O addresses: writes are ignored.
- memread and memwrite both high: the write commits at the edge, and memdata shows the pre-write value during that cycle.
- Timer: runs in all states.
  - prescaler counts 0..TIMER_DIV-1; on wrap, timer++ (8-bit, wraps FF->00).
  - ovf is sticky: set on the timer FF->00 transition.
  - ovf is cleared at the posedge where memread=1 and adr=IO_BASE+3 in RUN.
  - If a set and a clear occur in the same cycle, set wins.
- load_ptr saturates. No write is ever performed to an I/O address from the loader.

Test Plan:
1. Boot load: reset, then feed bytes 8'h20,8'h07,8'hA5 via load_valid, pulse load_done on cycle 4.
   → cpu_reset falls exactly 2 cycles after load_done (through RELEASE).
   → memread adr=2 returns 8'hA5.
   → load_ready=0 in RUN.
2. Auto-release: stream 240 bytes (0x00..0xEF) with load_done=0.
   → after the byte at 0xEF the FSM enters RELEASE, then RUN.
   → RAM[0xEF] is correct, and no I/O register changes.
3. LED and RAM R/W: in RUN, write 8'h3C to 0xF0 and 8'h55 to 0x10.
   → leds=8'h3C next cycle; reads return 8'h3C and 8'h55.
   → a write of 8'hFF to 0xF2 leaves the timer unaffected.
4. Switch sync: switches changes 8'h00→8'h81.
   → a read of 0xF1 returns 8'h00 for 2 cycles, then 8'h81.
5. Timer overflow (TIMER_DIV=4): after 1024 cycles from reset, ovf=1 and a read of 0xF3 returns 8'h01.
   → the next read returns 8'h00.
   → with a read aligned to the overflow cycle, ovf remains 1.
6. Reset mid-load: assert reset after 5 loader bytes.
   → state=LOAD, load_ptr=0, cpu_reset=1, leds=0 immediately (async).
   → the reload overwrites from address 0.

Source files
------------

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the 8-bit multicycle MIPS core: byte RAM, small I/O window,
// and a byte-serial boot loader that holds the core in reset until the image is in RAM.
module mips_mem_responder #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  IO_BASE   = 8'hF0,
  parameter int unsigned       TIMER_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  input  logic             load_done,
  output logic             load_ready,
  output logic             cpu_reset,
  output logic [7:0]       leds,
  input  logic [7:0]       switches
);

  // state   | meaning
  // LOAD    | loader fills RAM from address 0, core held in reset
  // RELEASE | one-cycle gap before the core is let go
  // RUN     | core owns the bus, loader ignored until reset
  typedef enum logic [1:0] {S_LOAD, S_RELEASE, S_RUN} state_t;

  localparam int unsigned      RAM_DEPTH = int'(IO_BASE);
  localparam int unsigned      PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [WIDTH-1:0] ADR_LEDS  = IO_BASE;
  localparam logic [WIDTH-1:0] ADR_SW    = IO_BASE + WIDTH'(1);
  localparam logic [WIDTH-1:0] ADR_TMR   = IO_BASE + WIDTH'(2);
  localparam logic [WIDTH-1:0] ADR_OVF   = IO_BASE + WIDTH'(3);
  localparam logic [WIDTH-1:0] LAST_RAM  = IO_BASE - WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]       leds_q, leds_d;
  logic [7:0]       timer_q, timer_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       sw_meta_q, sw_sync_q;
  logic [WIDTH-1:0] mem_q [RAM_DEPTH];

  logic             mem_we;
  logic [WIDTH-1:0] mem_waddr, mem_wdata;
  logic             tick;
  logic             is_ram;

  assign is_ram = (adr < IO_BASE);
  assign tick   = (presc_q == PW'(TIMER_DIV - 1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    leds_d     = leds_q;
    mem_we     = 1'b0;
    mem_waddr  = adr;
    mem_wdata  = writedata;
    load_ready = 1'b0;
    cpu_reset  = 1'b1;
    case (state_q)
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = WIDTH'(load_data);
          if (ptr_q != LAST_RAM) ptr_d = ptr_q + WIDTH'(1);
        end
        // the last RAM byte ends the load even without load_done
        if (load_done || (load_valid && ptr_q == LAST_RAM)) state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_RUN;
      S_RUN: begin
        cpu_reset = 1'b0;
        if (memwrite) begin
          if (is_ram) mem_we = 1'b1;
          else if (adr == ADR_LEDS) leds_d = writedata[7:0];
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    timer_d = tick ? timer_q + 8'd1 : timer_q;
    ovf_d   = ovf_q;
    if (state_q == S_RUN && memread && adr == ADR_OVF) ovf_d = 1'b0;
    if (tick && timer_q == 8'hFF) ovf_d = 1'b1;
  end

  // combinational read: the core latches memdata on the same edge it issues memread
  always_comb begin
    memdata = '0;
    if (state_q == S_RUN && memread) begin
      if (is_ram) memdata = mem_q[adr];
      else begin
        case (adr)
          ADR_LEDS: memdata = WIDTH'(leds_q);
          ADR_SW:   memdata = WIDTH'(sw_sync_q);
          ADR_TMR:  memdata = WIDTH'(timer_q);
          ADR_OVF:  memdata = WIDTH'(ovf_q);
          default:  memdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_LOAD;
      ptr_q     <= '0;
      leds_q    <= '0;
      timer_q   <= '0;
      presc_q   <= '0;
      ovf_q     <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      leds_q    <= leds_d;
      timer_q   <= timer_d;
      presc_q   <= presc_d;
      ovf_q     <= ovf_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: boot load, auto-release, I/O window, timer overflow.
module tb_mips_mem_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       memread = 1'b0, memwrite = 1'b0;
  logic [7:0] adr = 8'h00, writedata = 8'h00;
  logic [7:0] memdata;
  logic       load_valid = 1'b0, load_done = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready, cpu_reset;
  logic [7:0] leds;
  logic [7:0] switches = 8'h00;

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  mips_mem_responder #(.WIDTH(8), .IO_BASE(8'hF0), .TIMER_DIV(4)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .memdata(memdata),
    .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
    .load_ready(load_ready), .cpu_reset(cpu_reset), .leds(leds), .switches(switches)
  );

  always #5 clk = ~clk;

  // edges since reset release; timer model is cyc/TIMER_DIV mod 256
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_leds", leds, 8'h00);
    check("rst_cpu_reset", cpu_reset, 1'b1);
    check("rst_load_ready", load_ready, 1'b1);
    step();
    reset = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    memread = 1'b1;
    adr = a;
    #1;
    check(tag, memdata, exp);
    step();
    memread = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    memwrite = 1'b1;
    adr = a;
    writedata = d;
    step();
    memwrite = 1'b0;
  endtask

  task automatic feed(input logic [7:0] d);
    load_valid = 1'b1;
    load_data = d;
    step();
    load_valid = 1'b0;
  endtask

  task automatic boot_done();
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    step();
  endtask

  initial begin
    step();

    // boot load with explicit load_done
    do_reset();
    memread = 1'b1; adr = 8'h00; #1;
    check("load_rd_blocked", memdata, 8'h00);
    memread = 1'b0;
    feed(8'h20); feed(8'h07); feed(8'hA5);
    load_done = 1'b1; #1;
    check("done_cpu_reset", cpu_reset, 1'b1);
    step();
    load_done = 1'b0;
    check("release_cpu_reset", cpu_reset, 1'b1);
    check("release_load_ready", load_ready, 1'b0);
    step();
    check("run_cpu_reset", cpu_reset, 1'b0);
    check("run_load_ready", load_ready, 1'b0);
    rd("boot_rd2", 8'h02, 8'hA5);
    rd("boot_rd0", 8'h00, 8'h20);
    adr = 8'h00; #1;
    check("idle_memdata", memdata, 8'h00);

    // auto-release after the last RAM byte
    do_reset();
    for (int i = 0; i < 240; i++) feed(8'(i));
    check("auto_release_ready", load_ready, 1'b0);
    check("auto_release_cpu", cpu_reset, 1'b1);
    step();
    check("auto_run_cpu", cpu_reset, 1'b0);
    rd("auto_rd_ef", 8'hEF, 8'hEF);
    rd("auto_rd_10", 8'h10, 8'h10);
    rd("auto_leds", 8'hF0, 8'h00);

    // LED and RAM read/write
    wr(8'hF0, 8'h3C);
    check("leds_out", leds, 8'h3C);
    wr(8'h10, 8'h55);
    rd("rd_leds", 8'hF0, 8'h3C);
    rd("rd_ram10", 8'h10, 8'h55);
    wr(8'hF2, 8'hFF);
    rd("timer_no_wr", 8'hF2, 8'((cyc / 4) % 256));
    memread = 1'b1; memwrite = 1'b1; adr = 8'h20; writedata = 8'h99; #1;
    check("rw_prewrite", memdata, 8'h20);
    step();
    memread = 1'b0; memwrite = 1'b0;
    rd("rw_postwrite", 8'h20, 8'h99);

    // switch synchronizer latency
    switches = 8'h81;
    rd("sw_c0", 8'hF1, 8'h00);
    rd("sw_c1", 8'hF1, 8'h00);
    rd("sw_c2", 8'hF1, 8'h81);

    // timer overflow, clear-on-read, set beats clear
    do_reset();
    boot_done();
    while (cyc < 41) step();
    rd("timer_41", 8'hF2, 8'd10);
    while (cyc < 1023) step();
    rd("ovf_pre", 8'hF3, 8'h00);
    rd("ovf_set_wins", 8'hF3, 8'h01);
    rd("ovf_cleared", 8'hF3, 8'h00);
    rd("timer_wrap", 8'hF2, 8'((cyc / 4) % 256));

    // reset in the middle of a load, then reload from address 0
    do_reset();
    feed(8'h11); feed(8'h12); feed(8'h13); feed(8'h14); feed(8'h15);
    do_reset();
    feed(8'hAA); feed(8'hBB);
    boot_done();
    rd("reload_0", 8'h00, 8'hAA);
    rd("reload_1", 8'h01, 8'hBB);
    rd("reload_2", 8'h02, 8'h13);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
